// File: rtl/div_seq_if.sv
// rtl/div_seq_if.sv - start/busy/done handshake and operand/result bus for div_seq
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  q, r, busy, done, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output q, r, busy, done, div_zero
    );
endinterface

// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential restoring divider, one quotient bit per clock
module div_seq #(
    parameter int WIDTH  = 32,
    parameter int SIGNED = 1
) (
    input  logic     clk,
    input  logic     reset,
    div_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    // Shifted partial remainder and its trial difference; bit WIDTH of the
    // difference is the borrow that decides restore versus keep.
    logic [WIDTH:0]   shifted_w;
    logic [WIDTH:0]   trial_w;
    logic             a_neg_w;
    logic             b_neg_w;

    assign shifted_w = {rem_q, quo_q[WIDTH-1]};
    assign trial_w   = shifted_w - {1'b0, dvs_q};
    assign a_neg_w   = (SIGNED != 0) && bus.dividend[WIDTH-1];
    assign b_neg_w   = (SIGNED != 0) && bus.divisor[WIDTH-1];

    // Next-state and datapath: operands are taken as magnitudes, the signs are
    // reapplied in FIX so the core loop is always an unsigned divide.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        sign_q_d   = sign_q_q;
        sign_r_d   = sign_r_q;
        q_d        = q_q;
        r_d        = r_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    busy_d     = 1'b1;
                    div_zero_d = 1'b0;
                    if (bus.divisor == '0) begin
                        q_d        = '1;
                        r_d        = bus.dividend;
                        div_zero_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        quo_d    = a_neg_w ? (-bus.dividend) : bus.dividend;
                        dvs_d    = b_neg_w ? (-bus.divisor) : bus.divisor;
                        rem_d    = '0;
                        sign_q_d = a_neg_w ^ b_neg_w;
                        sign_r_d = a_neg_w;
                        count_d  = '0;
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (!trial_w[WIDTH]) begin
                    rem_d = trial_w[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted_w[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                q_d     = sign_q_q ? (-quo_q) : quo_q;
                r_d     = sign_r_q ? (-rem_q) : rem_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and working registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            sign_q_q   <= 1'b0;
            sign_r_q   <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            sign_q_q   <= sign_q_d;
            sign_r_q   <= sign_r_d;
            q_q        <= q_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.q        = q_q;
    assign bus.r        = r_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Sequential restoring divider: 32-bit dividend / 32-bit divisor gives a 32-bit quotient and a 32-bit remainder.
- Inverse companion of the MULT block. It sits beside MULT in the CPU's multiply/divide unit and serves DIV/DIVU.
- Produces one quotient bit per clock, under a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits.
- SIGNED, 1, 1 = two's-complement division (DIV semantics); 0 = unsigned division (DIVU semantics).

Ports:
- clk  input  1  rising-edge clock; sole clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  WIDTH  numerator; captured on the accepted start edge.
- divisor  input  WIDTH  denominator; captured on the accepted start edge.
- q  output  WIDTH  quotient; held until the next accepted start.
- r  output  WIDTH  remainder; held until the next accepted start.
- busy  output  1  high from the accepted start until done.
- done  output  1  one-cycle pulse; q and r are valid during it.
- div_zero  output  1  set with done when divisor was 0; cleared on next accepted start.

Behaviour:
- Reset (synchronous, active-high):
  - Sampled reset=1 forces state IDLE, with q=0, r=0, busy=0, done=0, div_zero=0.
  - Internal counter and working registers are cleared.
  - Reset overrides start in the same cycle. Reset mid-CALC aborts the operation and no done is issued.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 with divisor!=0 and no reset: latch operands, go to CALC, busy=1, count=0.
  - In SIGNED mode, latch the absolute values of both operands, plus sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - start=1 with divisor==0: go to DONE directly, with q = all ones, r = dividend, div_zero=1.
- CALC, one iteration per cycle for WIDTH cycles:
  - Shift {rem, quo} left by one.
  - Trial-subtract the divisor from the upper WIDTH+1 bits.
  - If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set it to 0.
  - After iteration WIDTH-1 (count == WIDTH-1), go to FIX.
- FIX, one cycle:
  - Negate the quotient if sign_q; negate the remainder if sign_r (SIGNED only).
  - Write q and r, then go to DONE.
- DONE, one cycle: done=1, busy=0, then return to IDLE.
  - start is ignored in DONE; it may be accepted from IDLE on the next cycle.
- Latency:
  - Normal operation: start sampled at edge E0, so done=1 during the cycle after edge E0+WIDTH+2 (WIDTH CALC edges + FIX + DONE entry). That is 34 edges for WIDTH=32.
  - Divide by zero: done=1 during the cycle after edge E0+1.
- Rounding: quotient truncates toward zero; the remainder takes the sign of the dividend, so dividend = q*divisor + r.
- Boundary conditions:
  - Overflow (SIGNED, dividend = 0x80000000, divisor = 0xFFFFFFFF): q = 0x80000000, r = 0. No flag, no trap.
  - Dividend 0 with a non-zero divisor: q = 0, r = 0, with full latency.
  - start while busy: ignored; the operation in progress and its operands are unaffected.
  - Operand inputs may change freely after the accepted start edge.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- SIGNED=1, dividend=0x00000008, divisor=0x00000005 -> done at edge E0+34; q=0x00000001, r=0x00000003, div_zero=0.
- SIGNED=1, dividend=0xFFFFFFF8 (-8), divisor=0xFFFFFFFB (-5) -> q=0x00000001, r=0xFFFFFFFD (-3).
- SIGNED=1, dividend=0x00000001, divisor=0xFFFFFFFF -> q=0xFFFFFFFF, r=0x00000000.
- SIGNED=1 edge cases:
  - 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0.
  - 0x12345678 / 0 -> done at E0+1; q=0xFFFFFFFF, r=0x12345678, div_zero=1.
- SIGNED=0, dividend=0xFFFFFFF8, divisor=0x00000005 -> q=0x33333331, r=0x00000003.
- Handshake and reset:
  - Pulse start again at E0+5 with different operands -> ignored; first result is unchanged.
  - Assert reset at E0+10 for 2 cycles -> busy=0, q=r=0, and no done pulse.
  - A new start after reset completes correctly.
